// File: rtl/bit_reverse_reorder_ctrl_pkg.sv
// Shared definitions for the bit-reversal reorder controller and related FFT address logic.
// Holds default frame geometry, the bank index type and a reusable bit-reverse helper.
package bit_reverse_reorder_ctrl_pkg;

  localparam int N_DEFAULT = 3;
  localparam int W_DEFAULT = 8;
  localparam int FRAME_LEN = 2 ** N_DEFAULT;

  // Widest address the helper function handles.
  localparam int ADDR_MAX = 16;

  typedef logic bank_t;

  // Reverse the low n bits of a: bit i moves to bit n-1-i, upper bits read as zero.
  function automatic logic [ADDR_MAX-1:0] bitrev(input logic [ADDR_MAX-1:0] a,
                                                 input int unsigned n);
    logic [ADDR_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ADDR_MAX; i++) begin
      if (i < n) r[n-1-i] = a[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse_reorder_ctrl_addr_bit_reverse.sv
// Combinational N-bit address bit reversal: out[i] = in[N-1-i].
// Pure wiring, so it costs no logic on the read address path.
module addr_bit_reverse #(
  parameter int N = 3
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  for (genvar i = 0; i < N; i++) begin : g_rev
    assign out[i] = in[N-1-i];
  end

endmodule

// File: rtl/bit_reverse_reorder_ctrl.sv
// Ping-pong frame buffer that accepts 2**N samples in natural order and
// emits each complete frame in bit-reversed index order.
module bit_reverse_reorder_ctrl
  import bit_reverse_reorder_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         busy
);

  localparam int             DEPTH   = 2 ** N;
  localparam logic [N-1:0]   CNT_MAX = '1;

  logic [W-1:0] mem [2][DEPTH];

  bank_t        wr_bank;
  bank_t        rd_bank;
  logic [N-1:0] wr_cnt;
  logic [N-1:0] rd_cnt;
  logic [1:0]   full;
  logic [N-1:0] rd_addr;

  logic s_fire;
  logic m_fire;

  // Ready and valid come from registered flags only, so s_ready never
  // depends combinationally on m_ready.
  assign s_ready = !full[wr_bank];
  assign m_valid = full[rd_bank];
  assign m_last  = m_valid && (rd_cnt == CNT_MAX);
  assign busy    = (|full) || (wr_cnt != '0);

  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  addr_bit_reverse #(
    .N (N)
  ) u_addr_bit_reverse (
    .in  (rd_cnt),
    .out (rd_addr)
  );

  assign m_data = mem[rd_bank][rd_addr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= '0;
    end else begin
      // Write only targets a non-full bank and read only a full one, so
      // the set and clear below never hit the same flag in one cycle.
      if (s_fire) begin
        wr_cnt <= wr_cnt + N'(1);
        if (wr_cnt == CNT_MAX) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (m_fire) begin
        rd_cnt <= rd_cnt + N'(1);
        if (rd_cnt == CNT_MAX) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

  // NOTE: the sample storage has no reset; the full flags alone decide what
  // is readable, so stale contents are never observed and the array stays
  // a plain register file without a reset network.
  always_ff @(posedge clk) begin
    if (s_fire) mem[wr_bank][wr_cnt] <= s_data;
  end

endmodule

// File: tb/tb_bit_reverse_reorder_ctrl.sv
// Self-checking bench for bit_reverse_reorder_ctrl (N=3, W=8): frame-level
// reference model plus directed and randomized traffic.
module tb_bit_reverse_reorder_ctrl;
  import bit_reverse_reorder_ctrl_pkg::*;

  localparam int N = 3;
  localparam int W = 8;
  localparam int L = 2 ** N;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  bit_reverse_reorder_ctrl #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [W-1:0] part_q[$];   // samples of the frame currently being received
  logic [W-1:0] exp_q[$];    // outputs still owed, already in bit-reversed order
  logic [W-1:0] out_log[$];  // everything the DUT emitted, for literal checks
  int held   = 0;            // complete frames not yet fully read out
  int rd_idx = 0;            // outputs already emitted from the head frame

  function automatic int rev3(input int k);
    int r = 0;
    for (int b = 0; b < N; b++) if (((k >> b) & 1) != 0) r += 1 << (N - 1 - b);
    return r;
  endfunction

  function automatic bit exp_s_ready(); return held < 2; endfunction
  function automatic bit exp_m_valid(); return held > 0; endfunction

  always @(posedge clk) begin
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      held   = 0;
      rd_idx = 0;
    end else begin
      bit in_fire, out_fire;
      in_fire  = s_valid && exp_s_ready();
      out_fire = m_ready && exp_m_valid();
      if (out_fire) begin
        out_log.push_back(m_data);
        void'(exp_q.pop_front());
        rd_idx++;
        if (rd_idx == L) begin
          rd_idx = 0;
          held--;
        end
      end
      if (in_fire) begin
        part_q.push_back(s_data);
        if (part_q.size() == L) begin
          for (int k = 0; k < L; k++) exp_q.push_back(part_q[rev3(k)]);
          part_q.delete();
          held++;
        end
      end
    end
  end

  // Compare process: outputs are settled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("s_ready", 32'(s_ready), 32'(exp_s_ready()));
      check("m_valid", 32'(m_valid), 32'(exp_m_valid()));
      check("m_last",  32'(m_last),  32'(exp_m_valid() && rd_idx == L - 1));
      check("busy",    32'(busy),    32'(held > 0 || part_q.size() != 0));
      if (exp_m_valid() && exp_q.size() > 0) check("m_data", 32'(m_data), 32'(exp_q[0]));
    end
  end

  // ---------------- stimulus ----------------
  // rpct: percent chance of m_ready each cycle; 200 means toggle every cycle.
  task automatic run(input int n, input int vpct, input int rpct, input int base,
                     input bit drain, input int max_cycles);
    int sent = 0;
    int cyc  = 0;
    bit fire;
    while ((sent < n || (drain && (exp_q.size() != 0 || part_q.size() != 0)))
           && cyc < max_cycles) begin
      s_valid = (sent < n) && ($urandom_range(99) < vpct);
      s_data  = W'(base + sent);
      if (rpct == 200) m_ready = cyc[0];
      else             m_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      fire = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (fire) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    check("run_completes_in_budget", 32'(cyc < max_cycles), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_seq(input string name, input int base);
    logic [W-1:0] want [8];
    want = '{0, 4, 2, 6, 1, 5, 3, 7};
    check({name, "_len"}, 32'(out_log.size()), 32'(L));
    for (int i = 0; i < L && i < out_log.size(); i++)
      check(name, 32'(out_log[i]), 32'(W'(base + int'(want[i]))));
  endtask

  initial begin
    int acc;
    bit fire;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    do_reset(2);
    check("reset_s_ready", 32'(s_ready), 32'd1);
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_m_last",  32'(m_last),  32'd0);
    check("reset_busy",    32'(busy),    32'd0);
    check("pkg_bitrev_1",  32'(bitrev(16'd1, 3)), 32'd4);
    check("pkg_bitrev_6",  32'(bitrev(16'd6, 3)), 32'd3);

    // 1. basic reorder, first output the cycle after the last input
    out_log.delete();
    m_ready = 1'b1;
    for (int i = 0; i < L; i++) begin
      s_valid = 1'b1; s_data = W'(i);
      @(posedge clk); #1;
      if (i < L - 1) check("t1_no_early_valid", 32'(m_valid), 32'd0);
    end
    s_valid = 1'b0;
    check("t1_first_valid", 32'(m_valid), 32'd1);
    check("t1_first_data",  32'(m_data),  32'd0);
    repeat (12) @(posedge clk);
    #1;
    check_seq("t1_seq", 0);

    // 2. three frames back to back, s_ready must never drop
    out_log.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 3 * L; i++) begin
      s_valid = 1'b1; s_data = W'(i);
      @(negedge clk);
      check("t2_s_ready_high", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t2_len", 32'(out_log.size()), 32'(3 * L));
    if (out_log.size() >= 3 * L) begin
      check("t2_out8",  32'(out_log[8]),  32'd8);
      check("t2_out9",  32'(out_log[9]),  32'd12);
      check("t2_out12", 32'(out_log[12]), 32'd9);
      check("t2_out17", 32'(out_log[17]), 32'd20);
      check("t2_out23", 32'(out_log[23]), 32'd23);
    end

    // 3. backpressure: exactly two frames fit
    m_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 25; c++) begin
      s_valid = 1'b1; s_data = W'(acc);
      @(negedge clk);
      fire = s_ready;
      @(posedge clk); #1;
      if (fire) acc++;
    end
    s_valid = 1'b0;
    check("t3_accepted", 32'(acc), 32'd16);
    check("t3_s_ready_low", 32'(s_ready), 32'd0);
    run(8, 100, 100, 16, 1'b1, 200);

    // 4. m_ready toggles every cycle during output
    run(L, 100, 0, 40, 1'b0, 50);
    run(0, 0, 200, 0, 1'b1, 100);

    // 5. reset mid-frame discards partial data
    run(5, 100, 100, 60, 1'b0, 50);
    do_reset(1);
    check("t5_s_ready", 32'(s_ready), 32'd1);
    check("t5_m_valid", 32'(m_valid), 32'd0);
    check("t5_busy",    32'(busy),    32'd0);
    out_log.delete();
    run(L, 100, 100, 100, 1'b1, 100);
    check_seq("t5_seq", 100);

    // 6. random valid/ready over 1000 frames
    run(1000 * L, 70, 60, 0, 1'b1, 60000);
    check("t6_model_drained", 32'(exp_q.size() + part_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
